mipi_csi_tx_raw_packer_16b4lane: RTL

- Transmit-side counterpart of the 4-lane RAW10 depacker.
- Accepts 8 pixels per beat on a 128-bit bus. Each pixel is 16 bits, with the 10-bit sample MSB-aligned.
- Packs them into the MIPI CSI RAW10 byte stream on a 64-bit (8 bytes/clk) bus, which feeds the CSI TX packet builder and lane distributor.
- Tracks the line boundary: flushes residual bytes zero-padded and reports the line payload byte count for the packet header word count.

---
 rtl/mipi_csi_tx_raw_packer_16b4lane.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mipi_csi_tx_raw_packer_16b4lane.sv
// RAW10 transmit packer: 8 MSB-aligned 16-bit pixels per beat in, CSI RAW10 byte stream
// out 8 bytes per clock, with zero-padded end-of-line flush and line word count.
module mipi_csi_tx_raw_packer_16b4lane #(
   parameter int WC_W = 16
) (
   input  logic            clk_i,
   input  logic            reset_n_i,
   input  logic            pixel_valid_i,
   output logic            pixel_ready_o,
   input  logic [127:0]    pixel_i,
   input  logic            pixel_last_i,
   output logic            data_valid_o,
   input  logic            data_ready_i,
   output logic [63:0]     data_o,
   output logic [3:0]      data_bytes_o,
   output logic            data_last_o,
   output logic [WC_W-1:0] word_count_o
);

   // Two 4-pixel groups -> 10 bytes: four MSB bytes, then the packed 2-bit LSBs (P0 lowest).
   function automatic logic [79:0] pack_beat(input logic [127:0] px);
      logic [79:0] b;
      logic [9:0]  s;
      logic [7:0]  low;
      b = 80'd0;
      for (int g = 0; g < 2; g++) begin
         low = 8'd0;
         for (int p = 0; p < 4; p++) begin
            s = px[16*(4*g+p)+6 +: 10];
            b[8*(5*g+p) +: 8] = s[9:2];
            low[2*p +: 2]     = s[1:0];
         end
         b[8*(5*g+4) +: 8] = low;
      end
      return b;
   endfunction

   logic [127:0]    buf_r;
   logic [4:0]      fill_r;
   logic            flush_r;
   logic [WC_W-1:0] cnt_r;
   logic            data_valid_r;
   logic [63:0]     data_r;
   logic [3:0]      data_bytes_r;
   logic            data_last_r;
   logic [WC_W-1:0] word_count_r;

   logic            pop_s;
   logic [3:0]      pop_bytes_s;
   logic            ready_s;
   logic            acc_s;
   logic [127:0]    buf_shift_s;
   logic [127:0]    buf_next_s;
   logic [4:0]      fill_after_s;
   logic [4:0]      fill_next_s;
   logic            flush_next_s;
   logic [WC_W-1:0] cnt_next_s;
   logic            cond_cur_s;
   logic            cond_next_s;
   logic            load_s;
   logic            is_last_s;

   // Next buffer state: pop oldest bytes first, then append the new beat behind what remains.
   always_comb begin
      pop_s = data_valid_r & data_ready_i;
      if (data_last_r) begin
         pop_bytes_s = data_bytes_r;
      end else begin
         pop_bytes_s = 4'd8;
      end
      ready_s = !flush_r && ((fill_r <= 5'd6) || ((fill_r <= 5'd14) && pop_s));
      acc_s   = pixel_valid_i & ready_s;

      if (pop_s) begin
         buf_shift_s  = buf_r >> {pop_bytes_s, 3'b000};
         fill_after_s = fill_r - {1'b0, pop_bytes_s};
      end else begin
         buf_shift_s  = buf_r;
         fill_after_s = fill_r;
      end

      if (acc_s) begin
         buf_next_s  = buf_shift_s | ({48'd0, pack_beat(pixel_i)} << {fill_after_s, 3'b000});
         fill_next_s = fill_after_s + 5'd10;
      end else begin
         buf_next_s  = buf_shift_s;
         fill_next_s = fill_after_s;
      end

      if (acc_s && pixel_last_i) begin
         flush_next_s = 1'b1;
      end else if (pop_s && data_last_r) begin
         flush_next_s = 1'b0;
      end else begin
         flush_next_s = flush_r;
      end

      if (pop_s && data_last_r) begin
         cnt_next_s = {WC_W{1'b0}};
      end else if (acc_s) begin
         cnt_next_s = cnt_r + WC_W'(10);
      end else begin
         cnt_next_s = cnt_r;
      end

      // A word is presented only once the buffer has qualified for a full cycle.
      cond_cur_s  = (fill_r >= 5'd8) || (flush_r && (fill_r != 5'd0));
      cond_next_s = (fill_next_s >= 5'd8) || (flush_next_s && (fill_next_s != 5'd0));
      load_s      = cond_cur_s & cond_next_s;
      is_last_s   = flush_next_s && (fill_next_s <= 5'd8);
   end

   // Byte buffer, fill level, flush flag and line byte counter.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         buf_r   <= 128'd0;
         fill_r  <= 5'd0;
         flush_r <= 1'b0;
         cnt_r   <= {WC_W{1'b0}};
      end else begin
         buf_r   <= buf_next_s;
         fill_r  <= fill_next_s;
         flush_r <= flush_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Registered output word; bytes past the fill level are already zero in the buffer.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         data_valid_r <= 1'b0;
         data_r       <= 64'd0;
         data_bytes_r <= 4'd0;
         data_last_r  <= 1'b0;
         word_count_r <= {WC_W{1'b0}};
      end else if (load_s) begin
         data_valid_r <= 1'b1;
         data_r       <= buf_next_s[63:0];
         if (is_last_s) begin
            data_bytes_r <= fill_next_s[3:0];
            data_last_r  <= 1'b1;
            word_count_r <= cnt_next_s;
         end else begin
            data_bytes_r <= 4'd8;
            data_last_r  <= 1'b0;
         end
      end else begin
         data_valid_r <= 1'b0;
         data_r       <= 64'd0;
         data_bytes_r <= 4'd0;
         data_last_r  <= 1'b0;
      end
   end

   assign pixel_ready_o = ready_s;
   assign data_valid_o  = data_valid_r;
   assign data_o        = data_r;
   assign data_bytes_o  = data_bytes_r;
   assign data_last_o   = data_last_r;
   assign word_count_o  = word_count_r;

endmodule
